uart_cmd_engine: RTL
====================

# uart_cmd_engine

Byte-level command sequencer sitting between `uartController` and the board fabric (LEDs, SMA outputs). It parses framed read/write commands arriving from the Raspberry Pi over the UART receive path. It maintains an 8 x 8-bit register bank and sequences exactly one response byte per command back through the UART transmit path, so a single host can configure the FPGA through the existing loopback-tested link.

## Interface
- `TIMEOUT_CYCLES`, default 50000000: inter-byte timeout in `clk` cycles; legal range is 2 to 2^32-1.
- `clk` input 1: system clock, rising edge. Driven from `CLK_0`.
- `rst` input 1: synchronous, active-high reset.
- `rx_recieved` input 1: one-cycle pulse from `uartController`; `rx_data` is valid in that cycle.
- `rx_data` input 8: received byte (`rx_output` of the controller).
- `tx_busy` input 1: high while the controller is shifting out a byte.
- `tx_start` output 1: one-cycle pulse requesting transmission of `tx_data`.
- `tx_data` output 8: byte to transmit; held stable from `tx_start` until the engine returns to IDLE.
- `reg_out` output 64: register bank, flattened; reg n occupies bits [8n+7:8n].
- `busy` output 1: high whenever the state is not IDLE.
- `err_count` output 8: saturating count of protocol errors.

## Operation
- Protocol:
  - Write: `0x57`, addr, data. Response `0x4B`.
  - Read: `0x52`, addr. Response is the register value.
  - Any other first byte is an unknown command. Response `0x3F`; no further bytes are consumed.
- Address is a full byte. An address of 8 or more gets response `0x3F`, makes no write, and increments `err_count`.
- States: IDLE, ADDR, DATA, EXEC, SEND, WAIT_TX.
- IDLE, on `rx_recieved`:
  - `0x57` goes to ADDR with a write flag set.
  - `0x52` goes to ADDR with the write flag clear.
  - Anything else goes to EXEC with a bad-command flag; `err_count` is incremented.
- ADDR, on `rx_recieved`: latch the address. Go to DATA if the write flag is set, otherwise go to EXEC.
- DATA, on `rx_recieved`: latch the data byte and go to EXEC.
- EXEC (always exactly 1 cycle): commit the write if it is valid, load `tx_data` with the response, go to SEND.
- SEND: while `tx_busy`=1, hold. When `tx_busy`=0, register `tx_start`=1 and go to WAIT_TX.
- WAIT_TX:
  - The first cycle is a guard cycle and is ignored.
  - From the second cycle on, return to IDLE when `tx_busy`=0.
- A `rx_recieved` pulse in EXEC, SEND or WAIT_TX is dropped, and `err_count` is incremented.
- `err_count` saturates at 255 and never wraps. It clears only on `rst`.
- Reset mid-operation: all state returns to reset values, including the register bank. A byte already handed to the controller is not aborted.

## Timing
- Reset values:
  - state IDLE
  - `tx_start` 0
  - `tx_data` 0x00
  - `reg_out` all zeros
  - `busy` 0
  - `err_count` 0
  - timeout counter 0
- All outputs are registered.
- Final command byte pulse in cycle T:
  - State is EXEC in T+1.
  - `reg_out` shows the written value from T+2.
  - State is SEND in T+2.
  - `tx_start` is high in T+3, provided `tx_busy` was 0 in T+2.
- `tx_start` is exactly one cycle wide, once per command.
- Read data is sampled in EXEC. A same-command write ordering hazard cannot occur.
- Simultaneous timeout expiry and `rx_recieved` in the same cycle: the byte wins and the counter restarts.
- `busy` rises the cycle after the first byte pulse. It falls the cycle after WAIT_TX exits.

## Configuration
- Macro `UART_CMD_TIMEOUT_EN`.
- Defined:
  - A 32-bit counter runs in ADDR and DATA. It is cleared on every accepted byte and on state entry.
  - On reaching `TIMEOUT_CYCLES`-1 with no byte, the engine returns to IDLE the next cycle. No response is sent and `err_count` is incremented.
- Undefined:
  - No counter is present.
  - ADDR and DATA wait indefinitely.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Write then read:
  - Stimulus: bytes 0x57, 0x03, 0xA5, then 0x52, 0x03.
  - Required: `reg_out[31:24]`=0xA5; `tx_data` 0x4B then 0xA5; two `tx_start` pulses.
  - Required: `tx_start` arrives 3 cycles after the final byte pulse.
- Bad inputs:
  - First byte 0x41 gives response 0x3F and `err_count`=1.
  - Bytes 0x57, 0x09, 0x11 give response 0x3F, `err_count` increments, and `reg_out` is unchanged.
- Transmit backpressure:
  - Stimulus: hold `tx_busy`=1 for 20 cycles after EXEC.
  - Required: no `tx_start` during those 20 cycles, then a single pulse on the cycle after `tx_busy` falls.
  - Required: a `rx_recieved` pulse during this wait is dropped and counted.
- Timeout (`UART_CMD_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16):
  - Stimulus: send 0x52 and stall.
  - Required: IDLE after 16 cycles, `err_count`=1, no `tx_start`.
  - Stimulus: a byte in the expiry cycle.
  - Required: the byte is accepted.
- Reset:
  - Stimulus: assert `rst` for 1 cycle while in DATA after writing reg 0 = 0xFF.
  - Required: all outputs at reset values on the next cycle.
  - Required: a fresh 0x52, 0x00 returns 0x00.
- Saturation:
  - Stimulus: 300 unknown command bytes.
  - Required: `err_count` holds at 255.

Source files
------------

// File: rtl/uart_cmd_engine.sv
// Framed read/write command sequencer over a byte UART link with an 8x8 register bank.
// Optional inter-byte timeout in ADDR/DATA is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_engine #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_recieved,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [63:0] reg_out,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, EXEC, SEND, WAIT_TX
    } state_t;

    state_t      state, next_state;
    logic        is_wr, bad_cmd, waited;
    logic [7:0]  addr, wdata;
    logic        tmo_hit, is_cmd, addr_bad;
    logic        err_ev, drop, wr_en, start_d;
    logic [7:0]  resp, err_next;
    logic [8:0]  err_sum;

    assign is_cmd   = (rx_data == CMD_WR) || (rx_data == CMD_RD);
    assign addr_bad = (addr[7:3] != 5'd0);

`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = ((state == ADDR) || (state == DATA))
                     && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

    // Cleared on state entry and on every accepted byte (both change state).
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= 32'd0;
        else if (((state == ADDR) || (state == DATA)) && (next_state == state))
            tmo_cnt <= tmo_cnt + 32'd1;
        else
            tmo_cnt <= 32'd0;
    end
`else
    // Never true for the legal parameter range; ADDR/DATA wait indefinitely.
    assign tmo_hit = (TIMEOUT_CYCLES == 32'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (rx_recieved) next_state = is_cmd ? ADDR : EXEC;
            ADDR:    if (rx_recieved) next_state = is_wr ? DATA : EXEC;
                     else if (tmo_hit) next_state = IDLE;
            DATA:    if (rx_recieved) next_state = EXEC;
                     else if (tmo_hit) next_state = IDLE;
            EXEC:    next_state = SEND;
            SEND:    if (!tx_busy) next_state = WAIT_TX;
            WAIT_TX: if (waited && !tx_busy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        err_ev  = 1'b0;
        drop    = 1'b0;
        wr_en   = 1'b0;
        start_d = 1'b0;
        resp    = RSP_ERR;
        unique case (state)
            IDLE:    err_ev = rx_recieved && !is_cmd;
            ADDR,
            DATA:    err_ev = !rx_recieved && tmo_hit;
            EXEC: begin
                drop   = rx_recieved;
                err_ev = !bad_cmd && addr_bad;
                wr_en  = is_wr && !bad_cmd && !addr_bad;
                if (!bad_cmd && !addr_bad)
                    resp = is_wr ? RSP_OK : reg_out[{addr[2:0], 3'b000} +: 8];
            end
            SEND: begin
                drop    = rx_recieved;
                start_d = !tx_busy;
            end
            WAIT_TX: drop = rx_recieved;
            default: ;
        endcase
    end

    // A dropped byte and a bad address can land in the same EXEC cycle.
    assign err_sum  = {1'b0, err_count} + {8'd0, err_ev} + {8'd0, drop};
    assign err_next = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            reg_out   <= 64'd0;
            busy      <= 1'b0;
            err_count <= 8'd0;
            is_wr     <= 1'b0;
            bad_cmd   <= 1'b0;
            waited    <= 1'b0;
            addr      <= 8'd0;
            wdata     <= 8'd0;
        end else begin
            tx_start  <= start_d;
            busy      <= (next_state != IDLE);
            err_count <= err_next;
            waited    <= (state == WAIT_TX);
            if ((state == IDLE) && rx_recieved) begin
                is_wr   <= (rx_data == CMD_WR);
                bad_cmd <= !is_cmd;
            end
            if ((state == ADDR) && rx_recieved)
                addr <= rx_data;
            if ((state == DATA) && rx_recieved)
                wdata <= rx_data;
            if (state == EXEC)
                tx_data <= resp;
            if (wr_en)
                reg_out[{addr[2:0], 3'b000} +: 8] <= wdata;
        end
    end

endmodule
